// File: rtl/wallace_tree_multiplier.sv
// rtl/wallace_tree_multiplier.sv - registered unsigned 8x8 Wallace-tree multiplier
// Rows are reduced three-at-a-time by carry-save rows: 8 -> 6 -> 4 -> 3 -> 2, then a ripple CPA.

module wallace_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic cout
);
  assign s    = a ^ b;
  assign cout = a & b;
endmodule

module wallace_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module wallace_csa_row (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic [15:0] s,
  output logic [15:0] c
);
  logic [14:0] co;

  for (genvar k = 0; k < 15; k++) begin : g_fa
    wallace_full_adder u_fa (.a(x[k]), .b(y[k]), .cin(z[k]), .s(s[k]), .cout(co[k]));
  end

  // Every row sum is bounded by the full product (< 2^16), so bit 15 never carries out.
  assign s[15] = x[15] ^ y[15] ^ z[15];
  assign c     = {co, 1'b0};
endmodule

module wallace_tree_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 out_valid
);
  logic [15:0] l0 [8];
  logic [15:0] l1 [6];
  logic [15:0] l2 [4];
  logic [15:0] l3 [3];
  logic [15:0] sum_row;
  logic [15:0] car_row;
  logic [15:0] product;
  logic [14:0] cpa_c;

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign l0[i] = {8'h00, A & {8{B[i]}}} << i;
  end

  wallace_csa_row u_l1_a (.x(l0[0]), .y(l0[1]), .z(l0[2]), .s(l1[0]), .c(l1[1]));
  wallace_csa_row u_l1_b (.x(l0[3]), .y(l0[4]), .z(l0[5]), .s(l1[2]), .c(l1[3]));
  assign l1[4] = l0[6];
  assign l1[5] = l0[7];

  wallace_csa_row u_l2_a (.x(l1[0]), .y(l1[1]), .z(l1[2]), .s(l2[0]), .c(l2[1]));
  wallace_csa_row u_l2_b (.x(l1[3]), .y(l1[4]), .z(l1[5]), .s(l2[2]), .c(l2[3]));

  wallace_csa_row u_l3   (.x(l2[0]), .y(l2[1]), .z(l2[2]), .s(l3[0]), .c(l3[1]));
  assign l3[2] = l2[3];

  wallace_csa_row u_l4   (.x(l3[0]), .y(l3[1]), .z(l3[2]), .s(sum_row), .c(car_row));

  wallace_half_adder u_cpa0 (.a(sum_row[0]), .b(car_row[0]), .s(product[0]), .cout(cpa_c[0]));
  for (genvar k = 1; k < 15; k++) begin : g_cpa
    wallace_full_adder u_fa (.a(sum_row[k]), .b(car_row[k]), .cin(cpa_c[k-1]),
                             .s(product[k]), .cout(cpa_c[k]));
  end
  assign product[15] = sum_row[15] ^ car_row[15] ^ cpa_c[14];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Y <= product;
    end
  end
endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// tb/tb_wallace_tree_multiplier.sv - self-checking bench for wallace_tree_multiplier
module tb_wallace_tree_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] Y;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [13];

  wallace_tree_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B), .Y(Y), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = v;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ref_y;
    logic        v;
    logic [7:0]  ra, rb;

    vecs[0]  = '{8'd1,   8'd1,   16'd1};
    vecs[1]  = '{8'd255, 8'd1,   16'd255};
    vecs[2]  = '{8'd1,   8'd255, 16'd255};
    vecs[3]  = '{8'd64,  8'd128, 16'd8192};
    vecs[4]  = '{8'd128, 8'd128, 16'd16384};
    vecs[5]  = '{8'd255, 8'd255, 16'd65025};
    vecs[6]  = '{8'd254, 8'd254, 16'd64516};
    vecs[7]  = '{8'd127, 8'd127, 16'd16129};
    vecs[8]  = '{8'hAA,  8'h55,  16'd14450};
    vecs[9]  = '{8'hF0,  8'h0F,  16'd3600};
    vecs[10] = '{8'hCC,  8'h33,  16'd10404};
    vecs[11] = '{8'hFF,  8'h81,  16'd32895};
    vecs[12] = '{8'd0,   8'd200, 16'd0};

    #12;
    chk("reset_y", Y, 0);
    chk("reset_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_y", i), Y, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
    end

    // async reset mid-run with a nonzero product held
    step(1'b1, 8'd200, 8'd3);
    chk("pre_reset_y", Y, 600);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_y", Y, 0);
    chk("async_reset_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'd0, 8'd123);
    chk("post_reset_y", Y, 0);
    chk("post_reset_valid", out_valid, 1);

    // streaming back-to-back
    step(1'b1, 8'd47, 8'd53);
    chk("stream0_y", Y, 2491);
    chk("stream0_valid", out_valid, 1);
    step(1'b1, 8'd200, 8'd200);
    chk("stream1_y", Y, 40000);
    chk("stream1_valid", out_valid, 1);
    step(1'b1, 8'd23, 8'd29);
    chk("stream2_y", Y, 667);
    chk("stream2_valid", out_valid, 1);

    // hold
    step(1'b1, 8'd250, 8'd250);
    chk("hold_load_y", Y, 62500);
    step(1'b0, 8'd7, 8'd9);
    chk("hold0_y", Y, 62500);
    chk("hold0_valid", out_valid, 0);
    step(1'b0, 8'd255, 8'd255);
    chk("hold1_y", Y, 62500);
    chk("hold1_valid", out_valid, 0);

    // random with gaps; reference holds the last accepted product
    ref_y = 16'd62500;
    for (int n = 0; n < 2000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (v) ref_y = 16'(int'(ra) * int'(rb));
      step(v, ra, rb);
      chk("rand_y", Y, ref_y);
      chk("rand_valid", out_valid, v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
